rf_write_ctrl: RTL and testbench

RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

---
 rtl/rf_write_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rf_write_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_ctrl.sv
// ---------------------------------------------------------------------------
// rf_write_ctrl
//
// Register-file write-port controller. After reset it optionally zero-fills
// x1..x31 (one write per cycle), then arbitrates between two writeback
// requesters (A = ALU, B = load unit) onto the single register-file write
// port. Contention is resolved by a one-bit preference pointer that flips
// to the losing requester whenever both ask in the same cycle.
//
// Parameters
//   INIT_EN   : 1 = zero-fill x1..x31 after reset, 0 = go straight to RUN
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous, active-low reset
//   a_valid   : ALU writeback request
//   a_addr    : ALU destination register
//   a_data    : ALU result
//   a_ready   : ALU request granted this cycle (combinational)
//   b_valid   : load-unit writeback request
//   b_addr    : load destination register
//   b_data    : load data
//   b_ready   : load request granted this cycle (combinational)
//   reg_write : register-file write enable (registered)
//   rd_addr   : register-file write address (registered)
//   rd_data   : register-file write data (registered)
//   init_done : zero-fill complete, arbitration active (registered)
// ---------------------------------------------------------------------------
module rf_write_ctrl #(
    parameter int unsigned INIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        reg_write,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Which requester wins a tie.
    localparam logic PREF_A = 1'b0;
    localparam logic PREF_B = 1'b1;

    localparam state_t     RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic [4:0] FILL_FIRST  = 5'd1;
    localparam logic [4:0] FILL_LAST   = 5'd31;

    // Registered state
    state_t       state_r;
    logic [4:0]   cnt_r;
    logic         pref_r;
    logic         reg_write_r;
    logic [4:0]   rd_addr_r;
    logic [31:0]  rd_data_r;
    logic         init_done_r;

    // Next-state values
    state_t       state_s;
    logic [4:0]   cnt_s;
    logic         pref_s;
    logic         reg_write_s;
    logic [4:0]   rd_addr_s;
    logic [31:0]  rd_data_s;
    logic         init_done_s;

    // Arbitration signals
    logic         run_s;
    logic         a_ready_s;
    logic         b_ready_s;
    logic         a_acc_s;
    logic         b_acc_s;

    // Grant logic: readies are combinational so a request is accepted in
    // the cycle it is presented. rst is folded in so that with INIT_EN=0
    // (state already RUN during reset) nothing is granted while reset is held.
    always_comb begin
        run_s     = (state_r == ST_RUN) && rst;
        a_ready_s = run_s && (!b_valid || (pref_r == PREF_A));
        b_ready_s = run_s && (!a_valid || (pref_r == PREF_B));
        a_acc_s   = a_valid && a_ready_s;
        b_acc_s   = b_valid && b_ready_s;
    end

    // Next-state and next-output logic for the INIT/RUN machine.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pref_s      = pref_r;
        reg_write_s = 1'b0;
        rd_addr_s   = rd_addr_r;
        rd_data_s   = rd_data_r;
        init_done_s = init_done_r;

        case (state_r)
            ST_INIT: begin
                reg_write_s = 1'b1;
                rd_addr_s   = cnt_r;
                rd_data_s   = 32'd0;
                if (cnt_r == FILL_LAST) begin
                    // Last fill write and init_done rise on the same edge.
                    state_s     = ST_RUN;
                    init_done_s = 1'b1;
                    cnt_s       = cnt_r;
                end else begin
                    cnt_s       = cnt_r + 5'd1;
                end
            end

            ST_RUN: begin
                init_done_s = 1'b1;
                if (a_acc_s) begin
                    // x0 is hard-wired zero: accept the request, drop the write.
                    reg_write_s = (a_addr != 5'd0);
                    rd_addr_s   = a_addr;
                    rd_data_s   = a_data;
                end else if (b_acc_s) begin
                    reg_write_s = (b_addr != 5'd0);
                    rd_addr_s   = b_addr;
                    rd_data_s   = b_data;
                end else begin
                    reg_write_s = 1'b0;
                end

                // On contention the loser becomes preferred next time.
                if (a_valid && b_valid) begin
                    pref_s = a_acc_s ? PREF_B : PREF_A;
                end else begin
                    pref_s = pref_r;
                end
            end

            default: begin
                state_s     = RESET_STATE;
                cnt_s       = FILL_FIRST;
                pref_s      = PREF_A;
                reg_write_s = 1'b0;
                rd_addr_s   = 5'd0;
                rd_data_s   = 32'd0;
                init_done_s = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= RESET_STATE;
            cnt_r       <= FILL_FIRST;
            pref_r      <= PREF_A;
            reg_write_r <= 1'b0;
            rd_addr_r   <= 5'd0;
            rd_data_r   <= 32'd0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pref_r      <= pref_s;
            reg_write_r <= reg_write_s;
            rd_addr_r   <= rd_addr_s;
            rd_data_r   <= rd_data_s;
            init_done_r <= init_done_s;
        end
    end

    assign a_ready   = a_ready_s;
    assign b_ready   = b_ready_s;
    assign reg_write = reg_write_r;
    assign rd_addr   = rd_addr_r;
    assign rd_data   = rd_data_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_rf_write_ctrl.sv
module tb_rf_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;

    logic        a_ready, b_ready, reg_write, init_done;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    logic        a_ready_0, b_ready_0, reg_write_0, init_done_0;
    logic [4:0]  rd_addr_0;
    logic [31:0] rd_data_0;

    always #5 clk = ~clk;

    rf_write_ctrl #(.INIT_EN(1)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .init_done(init_done)
    );

    rf_write_ctrl #(.INIT_EN(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready_0),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready_0),
        .reg_write(reg_write_0), .rd_addr(rd_addr_0), .rd_data(rd_data_0),
        .init_done(init_done_0)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        done;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic        m_pref;   // 0 = A preferred, 1 = B preferred
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        exp_t g;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            g = {init_done, reg_write, rd_addr, rd_data};
            check_eq(tag, 64'(g), 64'(e));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_we"},    64'(reg_write), 64'd0);
        check_eq({tag, "_addr"},  64'(rd_addr),   64'd0);
        check_eq({tag, "_data"},  64'(rd_data),   64'd0);
        check_eq({tag, "_done"},  64'(init_done), 64'd0);
        check_eq({tag, "_ardy"},  64'(a_ready),   64'd0);
        check_eq({tag, "_brdy"},  64'(b_ready),   64'd0);
        check_eq({tag, "_ardy0"}, 64'(a_ready_0), 64'd0);
        check_eq({tag, "_done0"}, 64'(init_done_0), 64'd0);
    endtask

    // Called away from the clock edge; releases reset just after a rising edge.
    task automatic apply_reset(input string tag);
        idle_inputs();
        a_valid = 1'b1;
        b_valid = 1'b1;
        rst = 1'b0;
        #2;
        check_outputs_zero(tag);
        m_pref = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        sb_q.delete();
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Run n fill cycles (addresses 1..n); A requests throughout and must be held off.
    task automatic init_phase(input int n);
        exp_t e;
        for (int c = 1; c <= n; c++) begin
            a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h5555_AAAA;
            b_valid = 1'b0;
            #1;
            check_eq("init_ardy", 64'(a_ready), 64'd0);
            check_eq("init_brdy", 64'(b_ready), 64'd0);
            e.done = (c == 31);
            e.we   = 1'b1;
            e.addr = 5'(c);
            e.data = 32'd0;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            pop_compare("init_write");
        end
        idle_inputs();
        m_addr = 5'(n);
        m_data = 32'd0;
    endtask

    // One RUN-phase cycle: drive requests, check readies against the model,
    // queue the expected write, then compare after the edge.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input string tag);
        logic ea, eb;
        exp_t e;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        ea = !bv || (m_pref == 1'b0);
        eb = !av || (m_pref == 1'b1);
        check_eq({tag, "_ardy"}, 64'(a_ready), 64'(ea));
        check_eq({tag, "_brdy"}, 64'(b_ready), 64'(eb));
        e.done = 1'b1;
        if (av && ea) begin
            e.we = (aa != 5'd0); m_addr = aa; m_data = ad;
        end else if (bv && eb) begin
            e.we = (ba != 5'd0); m_addr = ba; m_data = bd;
        end else begin
            e.we = 1'b0;
        end
        e.addr = m_addr;
        e.data = m_data;
        if (av && bv) m_pref = (av && ea) ? 1'b1 : 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_compare({tag, "_wr"});
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #3;

        // Reset, then full zero-fill
        apply_reset("por");
        init_phase(31);

        // Single ALU write
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, "alu_only");
        // Idle: no write, address/data held
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "idle_hold");
        // Load to x0: accepted, write dropped
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, "load_x0");
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0BAD_F00D, "load_only");

        // Mixed random traffic
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 "rand");
        end

        // Fresh reset, then four cycles of contention: A,B,A,B
        apply_reset("rst2");
        init_phase(31);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, "contend");
        end

        // Reset in the middle of the fill, right after address 10 is written
        apply_reset("rst3");
        init_phase(10);
        rst = 1'b0;
        #1;
        check_outputs_zero("midfill");
        sb_q.delete();
        m_pref = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        init_phase(31);
        step(1'b1, 5'd7, 32'h0000_0007, 1'b1, 5'd8, 32'h0000_0008, "after_refill");

        // INIT_EN=0 instance: request accepted on the very first edge after release
        idle_inputs();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hCAFE_F00D;
        rst = 1'b0;
        #2;
        check_eq("noinit_rst_ardy", 64'(a_ready_0), 64'd0);
        check_eq("noinit_rst_done", 64'(init_done_0), 64'd0);
        check_eq("noinit_rst_we",   64'(reg_write_0), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("noinit_ardy", 64'(a_ready_0), 64'd1);
        check_eq("noinit_done_pre", 64'(init_done_0), 64'd0);
        @(posedge clk);
        #1;
        check_eq("noinit_done", 64'(init_done_0), 64'd1);
        check_eq("noinit_we",   64'(reg_write_0), 64'd1);
        check_eq("noinit_addr", 64'(rd_addr_0),   64'd7);
        check_eq("noinit_data", 64'(rd_data_0),   64'hCAFE_F00D);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
